// File: rtl/fir_stream_analyzer_if.sv
// fir_stream_analyzer_if: sample stream, coefficient bank and frame-peak bundle for fir_stream_analyzer
interface fir_stream_analyzer_if #(parameter int DW = 16, TAPS = 32, CW = 20, FRAME = 16);
   logic data_valid, data_ready, flush, coef_we, fir_valid, fir_primed, busy, frame_valid;
   logic signed [DW-1:0] data, fir_d;
   logic [$clog2(TAPS/2)-1:0] coef_addr;
   logic signed [CW-1:0] coef_wdata;
   logic [$clog2(FRAME)-1:0] frame_peak_idx;
   logic [DW-1:0] frame_peak_val;
   modport master(output data_valid, data, flush, coef_we, coef_addr, coef_wdata,
                  input data_ready, fir_valid, fir_d, fir_primed, busy, frame_valid, frame_peak_idx, frame_peak_val);
   modport slave(input data_valid, data, flush, coef_we, coef_addr, coef_wdata,
                 output data_ready, fir_valid, fir_d, fir_primed, busy, frame_valid, frame_peak_idx, frame_peak_val);
endinterface

// File: rtl/fir_stream_analyzer.sv
// fir_stream_analyzer: symmetric FIR with one time-multiplexed pre-add MAC, output saturation and per-frame peak tracking
module fir_stream_analyzer #(parameter int DW = 16, TAPS = 32, CW = 20, FRAC = 16, FRAME = 16) (
   input logic clk,
   input logic rst,
   fir_stream_analyzer_if.slave s
);
   localparam int H = TAPS/2, AW = $clog2(H), XW = $clog2(TAPS), IW = $clog2(FRAME), NW = $clog2(TAPS+1);
   localparam int PW = DW+1+CW, ACW = PW+AW;
   localparam logic signed [ACW-1:0] HI = ACW'((2**(DW-1))-1), LO = ~HI;
   typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
   state_t st, nx;
   logic signed [DW-1:0] x [TAPS];
   logic signed [CW-1:0] c [H];
   logic signed [ACW-1:0] acc, sh;
   logic signed [DW:0] pa;
   logic signed [PW-1:0] pr;
   logic signed [DW-1:0] y;
   logic [DW-1:0] peak, mag;
   logic [AW-1:0] k;
   logic [XW-1:0] rk;
   logic [NW-1:0] cnt;
   logic [IW-1:0] idx, pidx;
   logic accept, upd, last;
   assign s.data_ready = st == IDLE && !s.flush;
   assign s.busy = st != IDLE;
   assign s.fir_primed = cnt == NW'(TAPS);
   always_comb begin
      accept = st == IDLE && s.data_valid && !s.flush;
      rk = XW'(TAPS-1) - XW'(k);
      pa = (DW+1)'(x[k]) + (DW+1)'(x[rk]);
      pr = PW'(pa) * PW'(c[k]);
      sh = acc >>> FRAC;
      y = sh > HI ? DW'(HI) : sh < LO ? DW'(LO) : DW'(sh);
      mag = y == DW'(LO) ? DW'(HI) : y[DW-1] ? DW'(-y) : DW'(y);
      upd = idx == '0 || mag > peak;
      last = idx == IW'(FRAME-1);
      nx = s.flush ? IDLE : st == IDLE ? (accept ? MAC : IDLE) : st == MAC ? (k == AW'(H-1) ? OUT : MAC) : IDLE;
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         st <= IDLE;
         acc <= '0;
         k <= '0;
         cnt <= '0;
         idx <= '0;
         pidx <= '0;
         peak <= '0;
         s.fir_valid <= 1'b0;
         s.frame_valid <= 1'b0;
         s.fir_d <= '0;
         s.frame_peak_idx <= '0;
         s.frame_peak_val <= '0;
         for (int i = 0; i < TAPS; i++) x[i] <= '0;
         for (int i = 0; i < H; i++) c[i] <= '0;
      end else begin
         st <= nx;
         s.fir_valid <= 1'b0;
         s.frame_valid <= 1'b0;
         if (s.coef_we && st == IDLE) c[s.coef_addr] <= s.coef_wdata;
         if (s.flush) begin
            for (int i = 0; i < TAPS; i++) x[i] <= '0;
            cnt <= '0;
            idx <= '0;
            pidx <= '0;
            peak <= '0;
         end else if (accept) begin
            x[0] <= s.data;
            for (int i = 1; i < TAPS; i++) x[i] <= x[i-1];
            acc <= '0;
            k <= '0;
            if (cnt != NW'(TAPS)) cnt <= cnt + NW'(1);
         end else if (st == MAC) begin
            acc <= acc + ACW'(pr);
            k <= k + AW'(1);
         end else if (st == OUT && s.fir_primed) begin
            s.fir_valid <= 1'b1;
            s.fir_d <= y;
            idx <= idx + IW'(1);
            if (upd) begin
               peak <= mag;
               pidx <= idx;
            end
            if (last) begin
               s.frame_valid <= 1'b1;
               s.frame_peak_idx <= upd ? idx : pidx;
               s.frame_peak_val <= upd ? mag : peak;
            end
         end
      end
endmodule

// File: tb/tb_fir_stream_analyzer.sv
// tb_fir_stream_analyzer: directed vector table plus hand-built flush, coefficient, frame-peak and async-reset sequences
module tb_fir_stream_analyzer;
   localparam int H = 16;
   logic clk = 0, rst = 1;
   always #5 clk = ~clk;
   fir_stream_analyzer_if #(.DW(16), .TAPS(32), .CW(20), .FRAME(16)) b();
   fir_stream_analyzer #(.DW(16), .TAPS(32), .CW(20), .FRAC(16), .FRAME(16)) dut(.clk(clk), .rst(rst), .s(b.slave));
   typedef struct {int coef; int din; int exp;} vec_t;
   vec_t v [10];
   int s [64];
   int checks = 0, errors = 0;
   bit got, fr;
   int d, lat, n0, nf;

   task automatic chk(input string n, input int a, input int e);
      checks++;
      if (a != e) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", n, a, e);
      end
   endtask

   task automatic send(input int val, input int cw_at, input int fl_at, output bit g, output int dd, output int l, output bit f);
      int t = 0;
      while (!b.data_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (t == 100) chk("ready_timeout", 0, 1);
      b.data = 16'(val);
      b.data_valid = 1;
      @(posedge clk);
      #1 b.data_valid = 0;
      g = 0; dd = 0; l = 0; f = 0;
      for (int i = 1; i <= H+1; i++) begin
         b.coef_we = i == cw_at;
         b.coef_addr = 0;
         b.coef_wdata = 1;
         b.flush = i == fl_at;
         @(posedge clk);
         #1;
         if (b.fir_valid && !g) begin
            g = 1;
            dd = int'(b.fir_d);
            l = i;
            f = b.frame_valid;
         end
      end
      b.coef_we = 0;
      b.flush = 0;
   endtask

   task automatic set_coef(input int k, input int val);
      @(negedge clk);
      b.coef_we = 1;
      b.coef_addr = 4'(k);
      b.coef_wdata = 20'(val);
      @(negedge clk);
      b.coef_we = 0;
   endtask

   task automatic set_all(input int val);
      for (int k = 0; k < H; k++) set_coef(k, val);
   endtask

   task automatic do_flush();
      @(negedge clk);
      b.flush = 1;
      @(negedge clk);
      b.flush = 0;
   endtask

   task automatic prime(input int val, output int cnt_early);
      cnt_early = 0;
      for (int n = 1; n < 32; n++) begin
         send(val, -1, -1, got, d, lat, fr);
         cnt_early += int'(got);
      end
      send(val, -1, -1, got, d, lat, fr);
   endtask

   initial begin
      #800000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      b.data_valid = 0; b.data = 0; b.flush = 0; b.coef_we = 0; b.coef_addr = 0; b.coef_wdata = 0;
      v[0] = '{4096, 1000, 2000};
      v[1] = '{65536, 30000, 32767};
      v[2] = '{65536, -30000, -32768};
      v[3] = '{4096, -1000, -2000};
      v[4] = '{-4096, 1000, -2000};
      v[5] = '{1, -1, -1};
      v[6] = '{1, 1, 0};
      v[7] = '{2048, 1000, 1000};
      v[8] = '{65536, -32768, -32768};
      v[9] = '{2048, 32767, 32767};
      for (int n = 0; n < 64; n++) s[n] = 0;
      s[19] = 500; s[20] = 500; s[25] = -500; s[26] = -500; s[40] = -32768; s[41] = -32768;
      #2 rst = 0;
      #10;
      chk("rst_fir_valid", b.fir_valid, 0);
      chk("rst_fir_d", b.fir_d, 0);
      chk("rst_primed", b.fir_primed, 0);
      chk("rst_busy", b.busy, 0);
      chk("rst_frame_valid", b.frame_valid, 0);
      chk("rst_peak_idx", b.frame_peak_idx, 0);
      chk("rst_peak_val", b.frame_peak_val, 0);
      chk("rst_ready", b.data_ready, 1);
      @(negedge clk) rst = 1;

      for (int e = 0; e < 10; e++) begin
         do_flush();
         set_all(v[e].coef);
         prime(v[e].din, n0);
         chk("unprimed_valid", n0, 0);
         chk("first_valid", got, 1);
         chk("latency", lat, 17);
         chk("y", d, v[e].exp);
         chk("primed", b.fir_primed, 1);
         if (e == 0)
            for (int n = 0; n < 8; n++) begin
               send(1000, -1, -1, got, d, lat, fr);
               chk("stream_y", got ? d : 99999, 2000);
            end
      end

      @(negedge clk);
      b.data_valid = 1; b.flush = 1;
      #1 chk("flush_prio_ready", b.data_ready, 0);
      @(posedge clk);
      #1 chk("flush_prio_busy", b.busy, 0);
      chk("flush_prio_primed", b.fir_primed, 0);
      b.data_valid = 0; b.flush = 0;

      set_all(4096);
      prime(1000, n0);
      chk("reprime_y", got ? d : 99999, 2000);
      send(1000, -1, 5, got, d, lat, fr);
      chk("flush_mac_valid", got, 0);
      chk("flush_mac_primed", b.fir_primed, 0);
      chk("flush_mac_busy", b.busy, 0);
      prime(1000, n0);
      chk("post_flush_unprimed", n0, 0);
      chk("post_flush_y", got ? d : 99999, 2000);

      send(1000, 3, -1, got, d, lat, fr);
      chk("coef_busy_y", got ? d : 99999, 2000);
      set_coef(0, 1);
      send(1000, -1, -1, got, d, lat, fr);
      chk("coef_idle_y", got ? d : 99999, 1875);

      do_flush();
      set_all(0);
      set_coef(15, 32768);
      n0 = 0; nf = 0;
      for (int n = 1; n < 64; n++) begin
         send(s[n], -1, -1, got, d, lat, fr);
         if (n < 32) n0 += int'(got);
         nf += int'(fr);
         if (n == 35) chk("frame_y3", d, 500);
         if (n == 41) chk("frame_y9", d, -500);
         if (n == 47) begin
            chk("frame1_valid", fr, 1);
            chk("frame1_idx", b.frame_peak_idx, 3);
            chk("frame1_val", b.frame_peak_val, 500);
         end
         if (n == 50) begin
            chk("frame_hold_pulse", fr, 0);
            chk("frame_hold_idx", b.frame_peak_idx, 3);
            chk("frame_hold_val", b.frame_peak_val, 500);
         end
         if (n == 56) chk("frame_y_min", d, -32768);
         if (n == 63) begin
            chk("frame2_valid", fr, 1);
            chk("frame2_idx", b.frame_peak_idx, 8);
            chk("frame2_val", b.frame_peak_val, 32767);
         end
      end
      chk("frame_unprimed", n0, 0);
      chk("frame_count", nf, 2);

      do_flush();
      set_all(4096);
      prime(1000, n0);
      chk("pre_reset_y", got ? d : 99999, 2000);
      @(negedge clk);
      b.data = 1000; b.data_valid = 1;
      @(posedge clk);
      #1 b.data_valid = 0;
      repeat (4) @(posedge clk);
      #1 chk("pre_reset_busy", b.busy, 1);
      #2 rst = 0;
      #1;
      chk("arst_busy", b.busy, 0);
      chk("arst_fir_d", b.fir_d, 0);
      chk("arst_primed", b.fir_primed, 0);
      chk("arst_peak_idx", b.frame_peak_idx, 0);
      chk("arst_peak_val", b.frame_peak_val, 0);
      chk("arst_fir_valid", b.fir_valid, 0);
      chk("arst_ready", b.data_ready, 1);
      @(negedge clk) rst = 1;
      prime(1000, n0);
      chk("arst_unprimed", n0, 0);
      chk("arst_coef_valid", got, 1);
      chk("arst_coef_y", d, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
